irq_scheduler: RTL and testbench

- Prioritised interrupt scheduler between the external `irq_src` lines and the CPU pipeline's IRQ entry logic.
- Captures rising edges on each source as pending events and applies a per-line mask.
- Tracks nested in-service levels and presents one stable request (`irq_req`, `irq_inum`) that the pipeline accepts with `irq_ack`.
- Retires the current level on `eret`. Sits beside the ID stage, ahead of the RC0 interrupt registers.

---
 rtl/irq_scheduler.sv | 157 +++++++++++++++
 tb/tb_irq_scheduler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/irq_scheduler.sv
// Prioritised, nesting interrupt scheduler: it synchronises and edge-captures the sources,
// masks them, and presents one held request to the pipeline until it is acked or withdrawn.
module irq_scheduler #(
    parameter int NIRQ     = 3,
    parameter int NBIT_IRQ = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NIRQ-1:0]     irq_src,
    input  logic                ie,
    input  logic                mask_we,
    input  logic [NIRQ-1:0]     mask_w,
    input  logic                irq_ack,
    input  logic                eret,
    output logic                irq_req,
    output logic [NBIT_IRQ-1:0] irq_inum,
    output logic [NIRQ-1:0]     pending,
    output logic [NIRQ-1:0]     in_service,
    output logic [NIRQ-1:0]     mask
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    function automatic logic [NIRQ-1:0] line_onehot(input logic [NBIT_IRQ-1:0] n);
        logic [NIRQ-1:0] v;
        for (int i = 0; i < NIRQ; i++) begin
            v[i] = (n == NBIT_IRQ'(i));
        end
        return v;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [NIRQ-1:0]     s1_r, s2_r, h_r;
    logic [NIRQ-1:0]     pending_r, in_service_r, mask_r;
    logic                irq_req_r, req_nxt_s;
    logic [NBIT_IRQ-1:0] irq_inum_r, inum_nxt_s;

    logic [NIRQ-1:0]     edge_s, cand_s, elig_s;
    logic [NBIT_IRQ-1:0] top_idx_s, best_s;
    logic                top_valid_s, any_elig_s;
    logic [NIRQ-1:0]     req_line_s, top_line_s;
    logic                ack_s, eret_fire_s;
    logic [NIRQ-1:0]     pending_nxt_s, in_service_nxt_s, mask_nxt_s;

    assign edge_s     = s2_r & ~h_r;
    assign cand_s     = pending_r & ~mask_r;
    assign req_line_s = line_onehot(irq_inum_r);
    assign top_line_s = line_onehot(top_idx_s);

    // Find the current nesting level and the best line allowed to pre-empt it.
    always_comb begin
        top_valid_s = 1'b0;
        top_idx_s   = '0;
        best_s      = '0;
        elig_s      = '0;
        for (int i = 0; i < NIRQ; i++) begin
            top_valid_s = top_valid_s | in_service_r[i];
            top_idx_s   = in_service_r[i] ? NBIT_IRQ'(i) : top_idx_s;
        end
        for (int i = 0; i < NIRQ; i++) begin
            elig_s[i] = cand_s[i] & (~top_valid_s | (NBIT_IRQ'(i) > top_idx_s));
            best_s    = elig_s[i] ? NBIT_IRQ'(i) : best_s;
        end
    end

    assign any_elig_s  = ie & (|elig_s);
    assign ack_s       = (state_r == REQ) & en & irq_ack;
    assign eret_fire_s = en & eret & top_valid_s;

    // Request FSM: the number is latched on entry to REQ and held until ack or withdrawal.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = irq_req_r;
        inum_nxt_s  = irq_inum_r;
        case (state_r)
            IDLE: begin
                if (any_elig_s) begin
                    state_nxt_s = REQ;
                    req_nxt_s   = 1'b1;
                    inum_nxt_s  = best_s;
                end else begin
                    req_nxt_s   = 1'b0;
                end
            end
            REQ: begin
                if (ack_s) begin
                    state_nxt_s = IDLE;
                    req_nxt_s   = 1'b0;
                end else if (!ie || (|(req_line_s & mask_r))) begin
                    state_nxt_s = IDLE;
                    req_nxt_s   = 1'b0;
                end else begin
                    req_nxt_s   = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                req_nxt_s   = 1'b0;
            end
        endcase
    end

    // A fresh edge wins over the ack clear of the same bit, so that event is not lost.
    always_comb begin
        pending_nxt_s    = (pending_r & ~({NIRQ{ack_s}} & req_line_s)) | edge_s;
        in_service_nxt_s = (in_service_r & ~({NIRQ{eret_fire_s}} & top_line_s))
                         | ({NIRQ{ack_s}} & req_line_s);
        if (en && mask_we) begin
            mask_nxt_s = mask_w;
        end else begin
            mask_nxt_s = mask_r;
        end
    end

    // Source synchroniser and edge-history flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= '0;
            s2_r <= '0;
            h_r  <= '0;
        end else begin
            s1_r <= irq_src;
            s2_r <= s1_r;
            h_r  <= s2_r;
        end
    end

    // Event, nesting, mask and request state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            pending_r    <= '0;
            in_service_r <= '0;
            mask_r       <= '0;
            irq_req_r    <= 1'b0;
            irq_inum_r   <= '0;
        end else begin
            state_r      <= state_nxt_s;
            pending_r    <= pending_nxt_s;
            in_service_r <= in_service_nxt_s;
            mask_r       <= mask_nxt_s;
            irq_req_r    <= req_nxt_s;
            irq_inum_r   <= inum_nxt_s;
        end
    end

    assign irq_req    = irq_req_r;
    assign irq_inum   = irq_inum_r;
    assign pending    = pending_r;
    assign in_service = in_service_r;
    assign mask       = mask_r;

endmodule

// File: tb/tb_irq_scheduler.sv
// Directed bench for irq_scheduler: inputs change and outputs are sampled on the falling edge.
module tb_irq_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [2:0] irq_src = 3'b000;
    logic       ie = 1'b1;
    logic       mask_we = 1'b0;
    logic [2:0] mask_w = 3'b000;
    logic       irq_ack = 1'b0;
    logic       eret = 1'b0;
    logic       irq_req;
    logic [1:0] irq_inum;
    logic [2:0] pending, in_service, mask;

    int total = 0;
    int bad = 0;

    irq_scheduler #(.NIRQ(3), .NBIT_IRQ(2)) dut (
        .clk(clk), .rst(rst), .en(en), .irq_src(irq_src), .ie(ie),
        .mask_we(mask_we), .mask_w(mask_w), .irq_ack(irq_ack), .eret(eret),
        .irq_req(irq_req), .irq_inum(irq_inum), .pending(pending),
        .in_service(in_service), .mask(mask)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL rst_pending got=%b want=000", pending); end
        total++; if (in_service !== 3'b000) begin bad++; $display("FAIL rst_in_service got=%b want=000", in_service); end
        total++; if (mask !== 3'b000) begin bad++; $display("FAIL rst_mask got=%b want=000", mask); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", irq_req); end
        total++; if (irq_inum !== 2'd0) begin bad++; $display("FAIL rst_inum got=%0d want=0", irq_inum); end
    endtask

    task automatic test_capture;
        irq_src = 3'b010;
        step(2);
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL cap_early got=%b want=000", pending); end
        step(1);
        total++; if (pending !== 3'b010) begin bad++; $display("FAIL cap_pending got=%b want=010", pending); end
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL cap_req_early got=%b want=0", irq_req); end
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd1) begin bad++; $display("FAIL cap_req got=%b/%0d want=1/1", irq_req, irq_inum); end
        step(2);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd1) begin bad++; $display("FAIL cap_hold got=%b/%0d want=1/1", irq_req, irq_inum); end
    endtask

    task automatic test_ack_nesting;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL ack_req got=%b want=0", irq_req); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL ack_pending got=%b want=000", pending); end
        total++; if (in_service !== 3'b010) begin bad++; $display("FAIL ack_is got=%b want=010", in_service); end
        irq_src = 3'b001;
        step(5);
        total++; if (pending !== 3'b001 || irq_req !== 1'b0) begin bad++; $display("FAIL nest_low got=%b/%b want=001/0", pending, irq_req); end
        irq_src = 3'b101;
        step(4);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd2) begin bad++; $display("FAIL nest_high got=%b/%0d want=1/2", irq_req, irq_inum); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        total++; if (in_service !== 3'b110 || pending !== 3'b001) begin bad++; $display("FAIL nest_ack got=%b/%b want=110/001", in_service, pending); end
        step(3);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL nest_blocked got=%b want=0", irq_req); end
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        total++; if (in_service !== 3'b110 || pending !== 3'b001) begin bad++; $display("FAIL idle_ack got=%b/%b want=110/001", in_service, pending); end
    endtask

    task automatic test_eret;
        ie = 1'b0;
        en = 1'b0;
        eret = 1'b1;
        step(1);
        eret = 1'b0;
        en = 1'b1;
        total++; if (in_service !== 3'b110) begin bad++; $display("FAIL eret_en0 got=%b want=110", in_service); end
        eret = 1'b1; step(1); eret = 1'b0; step(1);
        total++; if (in_service !== 3'b010) begin bad++; $display("FAIL eret_1 got=%b want=010", in_service); end
        eret = 1'b1; step(1); eret = 1'b0; step(1);
        total++; if (in_service !== 3'b000) begin bad++; $display("FAIL eret_2 got=%b want=000", in_service); end
        eret = 1'b1; step(1); eret = 1'b0; step(1);
        total++; if (in_service !== 3'b000) begin bad++; $display("FAIL eret_3 got=%b want=000", in_service); end
    endtask

    task automatic test_mask;
        irq_src = 3'b001;
        step(3);
        irq_src = 3'b101;
        step(3);
        total++; if (pending !== 3'b101) begin bad++; $display("FAIL mask_pend got=%b want=101", pending); end
        mask_we = 1'b1; mask_w = 3'b100;
        step(1);
        mask_we = 1'b0;
        total++; if (mask !== 3'b100 || irq_req !== 1'b0) begin bad++; $display("FAIL mask_wr got=%b/%b want=100/0", mask, irq_req); end
        ie = 1'b1;
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd0) begin bad++; $display("FAIL mask_req0 got=%b/%0d want=1/0", irq_req, irq_inum); end
        mask_we = 1'b1; mask_w = 3'b001;
        step(1);
        mask_we = 1'b0;
        total++; if (mask !== 3'b001 || irq_req !== 1'b1 || irq_inum !== 2'd0) begin bad++; $display("FAIL mask_wr2 got=%b/%b/%0d want=001/1/0", mask, irq_req, irq_inum); end
        step(1);
        total++; if (irq_req !== 1'b0 || pending !== 3'b101) begin bad++; $display("FAIL mask_withdraw got=%b/%b want=0/101", irq_req, pending); end
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd2) begin bad++; $display("FAIL mask_req2 got=%b/%0d want=1/2", irq_req, irq_inum); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        total++; if (in_service !== 3'b100 || pending !== 3'b001) begin bad++; $display("FAIL mask_ack got=%b/%b want=100/001", in_service, pending); end
        eret = 1'b1; step(1); eret = 1'b0;
        step(2);
        total++; if (in_service !== 3'b000 || irq_req !== 1'b0) begin bad++; $display("FAIL mask_quiet got=%b/%b want=000/0", in_service, irq_req); end
    endtask

    task automatic test_ie_drop;
        irq_src = 3'b111;
        step(3);
        total++; if (pending !== 3'b011) begin bad++; $display("FAIL ie_pend got=%b want=011", pending); end
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd1) begin bad++; $display("FAIL ie_req got=%b/%0d want=1/1", irq_req, irq_inum); end
        ie = 1'b0;
        step(1);
        total++; if (irq_req !== 1'b0 || pending !== 3'b011) begin bad++; $display("FAIL ie_drop got=%b/%b want=0/011", irq_req, pending); end
        ie = 1'b1;
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd1) begin bad++; $display("FAIL ie_restore got=%b/%0d want=1/1", irq_req, irq_inum); end
    endtask

    task automatic test_collision;
        irq_src = 3'b101;
        step(3);
        total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL col_hold got=%b want=1", irq_req); end
        irq_src = 3'b111;
        step(2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        total++; if (pending !== 3'b011 || in_service !== 3'b010) begin bad++; $display("FAIL col_set_wins got=%b/%b want=011/010", pending, in_service); end
        step(3);
        total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL col_quiet got=%b want=0", irq_req); end
    endtask

    task automatic test_reset_mid_req;
        irq_src = 3'b011;
        step(3);
        irq_src = 3'b111;
        step(4);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd2) begin bad++; $display("FAIL rreq_req got=%b/%0d want=1/2", irq_req, irq_inum); end
        rst = 1'b1;
        irq_src = 3'b000;
        step(1);
        rst = 1'b0;
        total++; if ({irq_req, irq_inum, pending, in_service, mask} !== 12'h000) begin bad++; $display("FAIL rreq_clear got=%b/%0d/%b/%b/%b want=all0", irq_req, irq_inum, pending, in_service, mask); end
        step(5);
        total++; if (irq_req !== 1'b0 || pending !== 3'b000) begin bad++; $display("FAIL rreq_quiet got=%b/%b want=0/000", irq_req, pending); end
        irq_src = 3'b001;
        step(3);
        total++; if (pending !== 3'b001) begin bad++; $display("FAIL rreq_pend got=%b want=001", pending); end
        step(1);
        total++; if (irq_req !== 1'b1 || irq_inum !== 2'd0) begin bad++; $display("FAIL rreq_fresh got=%b/%0d want=1/0", irq_req, irq_inum); end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_ack_nesting();
        test_eret();
        test_mask();
        test_ie_drop();
        test_collision();
        test_reset_mid_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
